// File: rtl/execution_stage_pkg.sv
// Shared opcode map and flag bit positions for the EX stage.
package exec_pkg;
  localparam logic [4:0] OP_ADD  = 5'b00000;
  localparam logic [4:0] OP_ADC  = 5'b00001;
  localparam logic [4:0] OP_SUB  = 5'b00010;
  localparam logic [4:0] OP_SBB  = 5'b00011;
  localparam logic [4:0] OP_AND  = 5'b00100;
  localparam logic [4:0] OP_OR   = 5'b00101;
  localparam logic [4:0] OP_XOR  = 5'b00110;
  localparam logic [4:0] OP_NOT  = 5'b00111;
  localparam logic [4:0] OP_NOR  = 5'b01000;
  localparam logic [4:0] OP_XNOR = 5'b01001;
  localparam logic [4:0] OP_SHL  = 5'b01010;
  localparam logic [4:0] OP_SHR  = 5'b01011;
  localparam logic [4:0] OP_ASR  = 5'b01100;
  localparam logic [4:0] OP_ROL  = 5'b01101;
  localparam logic [4:0] OP_ROR  = 5'b01110;
  localparam logic [4:0] OP_INC  = 5'b01111;
  localparam logic [4:0] OP_DEC  = 5'b10000;
  localparam logic [4:0] OP_MOV  = 5'b10001;
  localparam logic [4:0] OP_NEG  = 5'b10010;
  localparam logic [4:0] OP_CMP  = 5'b10011;
  localparam logic [4:0] OP_MULL = 5'b10100;
  localparam logic [4:0] OP_MULH = 5'b10101;
  localparam logic [4:0] OP_PASS = 5'b10110;
  localparam logic [4:0] OP_SWAP = 5'b10111;
  localparam logic [4:0] OP_LDI  = 5'b11000;
  localparam logic [4:0] OP_LD   = 5'b11001;
  localparam logic [4:0] OP_ST   = 5'b11010;
  localparam logic [4:0] OP_SLT  = 5'b11011;
  localparam logic [4:0] OP_SLTU = 5'b11100;
  localparam logic [4:0] OP_SEQ  = 5'b11101;
  localparam logic [4:0] OP_SNE  = 5'b11110;
  localparam logic [4:0] OP_NOP  = 5'b11111;

  localparam int FLAG_C = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_N = 1;
  localparam int FLAG_V = 0;
endpackage

// File: rtl/execution_stage_if.sv
// Decode-to-EX inputs and EX/MEM boundary outputs of the execute stage.
interface execution_stage_if #(parameter int WIDTH = 8, parameter int RW_W = 5) ();
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [WIDTH-1:0] data_in;
  logic [4:0]       op_dec;
  logic             mem_en_dec;
  logic             mem_rw_dec;
  logic             mem_mux_sel_dec;
  logic [RW_W-1:0]  RW_dec;
  logic [WIDTH-1:0] ans_ex;
  logic [3:0]       flag_ex;
  logic [WIDTH-1:0] data_out;
  logic [WIDTH-1:0] B_Bypass;
  logic             mem_en_ex;
  logic             mem_rw_ex;
  logic             mem_mux_sel_ex;
  logic [RW_W-1:0]  RW_ex;

  modport master (
    output A, B, data_in, op_dec, mem_en_dec, mem_rw_dec, mem_mux_sel_dec, RW_dec,
    input  ans_ex, flag_ex, data_out, B_Bypass, mem_en_ex, mem_rw_ex, mem_mux_sel_ex, RW_ex
  );
  modport slave (
    input  A, B, data_in, op_dec, mem_en_dec, mem_rw_dec, mem_mux_sel_dec, RW_dec,
    output ans_ex, flag_ex, data_out, B_Bypass, mem_en_ex, mem_rw_ex, mem_mux_sel_ex, RW_ex
  );
endinterface

// File: rtl/execution_stage_alu.sv
// Combinational ALU: one result plus C/Z/N/V per opcode; CMP and NOP ask the
// stage to keep the previous answer / flags respectively.
module exec_alu
  import exec_pkg::*;
#(parameter int WIDTH = 8) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] data_in,
  input  logic [4:0]       op,
  input  logic             carry_in,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       flags,
  output logic             hold_ans,
  output logic             hold_flags
);
  localparam int M = WIDTH - 1;
  localparam int H = WIDTH / 2;

  logic [WIDTH:0]     ext;
  logic [2*WIDTH-1:0] prod;
  logic               c, v;

  always_comb begin
    result     = '0;
    ext        = '0;
    c          = 1'b0;
    v          = 1'b0;
    hold_ans   = 1'b0;
    hold_flags = 1'b0;
    prod       = (2*WIDTH)'(a) * (2*WIDTH)'(b);
    case (op)
      OP_ADD, OP_LD, OP_ST, OP_ADC: begin
        ext    = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, (op == OP_ADC) & carry_in};
        result = ext[M:0];
        c      = ext[WIDTH];
        v      = (a[M] == b[M]) && (result[M] != a[M]);
      end
      // ext[WIDTH] of the widened difference is the borrow
      OP_SUB, OP_CMP, OP_SBB: begin
        ext      = {1'b0, a} - {1'b0, b} - {{WIDTH{1'b0}}, (op == OP_SBB) & carry_in};
        result   = ext[M:0];
        c        = ext[WIDTH];
        v        = (a[M] != b[M]) && (result[M] != a[M]);
        hold_ans = (op == OP_CMP);
      end
      OP_NEG: begin
        ext    = {(WIDTH+1){1'b0}} - {1'b0, a};
        result = ext[M:0];
        c      = ext[WIDTH];
        v      = a[M] & result[M];
      end
      OP_INC: begin
        ext    = {1'b0, a} + (WIDTH+1)'(1);
        result = ext[M:0];
        c      = ext[WIDTH];
        v      = ~a[M] & result[M];
      end
      OP_DEC: begin
        ext    = {1'b0, a} - (WIDTH+1)'(1);
        result = ext[M:0];
        c      = ext[WIDTH];
        v      = a[M] & ~result[M];
      end
      OP_AND:  result = a & b;
      OP_OR:   result = a | b;
      OP_XOR:  result = a ^ b;
      OP_NOT:  result = ~a;
      OP_NOR:  result = ~(a | b);
      OP_XNOR: result = ~(a ^ b);
      OP_SHL:  begin result = {a[M-1:0], 1'b0};  c = a[M]; end
      OP_SHR:  begin result = {1'b0, a[M:1]};    c = a[0]; end
      OP_ASR:  begin result = {a[M], a[M:1]};    c = a[0]; end
      OP_ROL:  result = {a[M-1:0], a[M]};
      OP_ROR:  result = {a[0], a[M:1]};
      OP_MOV:  result = b;
      OP_MULL, OP_MULH: begin
        result = (op == OP_MULH) ? prod[2*WIDTH-1:WIDTH] : prod[M:0];
        c      = |prod[2*WIDTH-1:WIDTH];
        v      = c;
      end
      OP_PASS: result = a;
      OP_SWAP: result = {a[H-1:0], a[M:H]};
      OP_LDI:  result = data_in;
      OP_SLT:  result = WIDTH'($signed(a) < $signed(b));
      OP_SLTU: result = WIDTH'(a < b);
      OP_SEQ:  result = WIDTH'(a == b);
      OP_SNE:  result = WIDTH'(a != b);
      default: hold_flags = 1'b1;  // NOP: answer 0, flags kept
    endcase
    flags         = '0;
    flags[FLAG_C] = c;
    flags[FLAG_Z] = (result == '0);
    flags[FLAG_N] = result[M];
    flags[FLAG_V] = v;
  end
endmodule

// File: rtl/execution_stage.sv
// EX stage: ALU plus the EX/MEM pipeline register with synchronous active-low reset.
module execution_stage
  import exec_pkg::*;
#(parameter int WIDTH = 8, parameter int RW_W = 5) (
  input logic               clk,
  input logic               reset,
  execution_stage_if.slave  bus
);
  logic [WIDTH-1:0] alu_result;
  logic [3:0]       alu_flags;
  logic             hold_ans, hold_flags;

  exec_alu #(.WIDTH(WIDTH)) u_alu (
    .a          (bus.A),
    .b          (bus.B),
    .data_in    (bus.data_in),
    .op         (bus.op_dec),
    .carry_in   (bus.flag_ex[FLAG_C]),
    .result     (alu_result),
    .flags      (alu_flags),
    .hold_ans   (hold_ans),
    .hold_flags (hold_flags)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      bus.ans_ex         <= '0;
      bus.flag_ex        <= '0;
      bus.data_out       <= '0;
      bus.B_Bypass       <= '0;
      bus.mem_en_ex      <= 1'b0;
      bus.mem_rw_ex      <= 1'b0;
      bus.mem_mux_sel_ex <= 1'b0;
      bus.RW_ex          <= '0;
    end else begin
      if (!hold_ans)   bus.ans_ex  <= alu_result;
      if (!hold_flags) bus.flag_ex <= alu_flags;
      bus.data_out       <= bus.data_in;
      bus.B_Bypass       <= bus.B;
      bus.mem_en_ex      <= bus.mem_en_dec;
      bus.mem_rw_ex      <= bus.mem_rw_dec;
      bus.mem_mux_sel_ex <= bus.mem_mux_sel_dec;
      bus.RW_ex          <= bus.RW_dec;
    end
  end
endmodule

// File: tb/tb_execution_stage.sv
// Directed-vector bench for execution_stage with hand-computed expectations.
module tb_execution_stage;
  import exec_pkg::*;

  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad   = 0;

  execution_stage_if #(.WIDTH(8), .RW_W(5)) bus ();

  execution_stage #(.WIDTH(8), .RW_W(5)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // apply one operation, clock it, sample 1 time unit after the edge
  task automatic step(input logic [4:0] op, input logic [7:0] a, input logic [7:0] b);
    bus.op_dec = op;
    bus.A      = a;
    bus.B      = b;
    @(posedge clk);
    #1;
  endtask

  task automatic exp_alu(input string tag, input logic [7:0] ans, input logic [3:0] fl);
    chk({tag, ".ans"}, bus.ans_ex, ans);
    chk({tag, ".flag"}, {4'h0, bus.flag_ex}, {4'h0, fl});
  endtask

  task automatic exp_ctl(input string tag, input logic [7:0] dout, input logic [7:0] bb,
                         input logic [2:0] mem, input logic [4:0] rw);
    chk({tag, ".data_out"}, bus.data_out, dout);
    chk({tag, ".B_Bypass"}, bus.B_Bypass, bb);
    chk({tag, ".mem"}, {5'h0, bus.mem_en_ex, bus.mem_rw_ex, bus.mem_mux_sel_ex}, {5'h0, mem});
    chk({tag, ".RW_ex"}, {3'h0, bus.RW_ex}, {3'h0, rw});
  endtask

  initial begin
    reset               = 1'b0;
    bus.data_in         = 8'h08;
    bus.mem_en_dec      = 1'b1;
    bus.mem_rw_dec      = 1'b1;
    bus.mem_mux_sel_dec = 1'b1;
    bus.RW_dec          = 5'd5;

    // reset with live inputs clears everything
    step(OP_ADD, 8'h40, 8'hC0);
    exp_alu("rst", 8'h00, 4'b0000);
    exp_ctl("rst", 8'h00, 8'h00, 3'b000, 5'd0);

    reset               = 1'b1;
    bus.mem_en_dec      = 1'b0;
    bus.mem_rw_dec      = 1'b0;
    bus.mem_mux_sel_dec = 1'b0;
    step(OP_ADD, 8'h40, 8'hC0);
    exp_alu("add", 8'h00, 4'b1100);
    exp_ctl("add", 8'h08, 8'hC0, 3'b000, 5'd5);
    step(OP_ADC, 8'h40, 8'hC0);  exp_alu("adc", 8'h01, 4'b1000);
    step(OP_SUB, 8'h40, 8'hC0);  exp_alu("sub", 8'h80, 4'b1011);
    step(OP_AND, 8'h40, 8'hC0);  exp_alu("and", 8'h40, 4'b0000);
    step(OP_OR,  8'h40, 8'hC0);  exp_alu("or",  8'hC0, 4'b0010);
    step(OP_XOR, 8'h40, 8'hC0);  exp_alu("xor", 8'h80, 4'b0010);
    step(OP_SHL, 8'h40, 8'hC0);  exp_alu("shl", 8'h80, 4'b0010);

    // load address with all memory controls asserted
    bus.mem_en_dec      = 1'b1;
    bus.mem_rw_dec      = 1'b1;
    bus.mem_mux_sel_dec = 1'b1;
    bus.RW_dec          = 5'd10;
    step(OP_LD, 8'hC0, 8'h01);
    exp_alu("ld", 8'hC1, 4'b0010);
    exp_ctl("ld", 8'h08, 8'h01, 3'b111, 5'd10);
    bus.mem_en_dec      = 1'b0;
    bus.mem_rw_dec      = 1'b0;
    bus.mem_mux_sel_dec = 1'b0;
    step(OP_ST, 8'h7F, 8'h01);   exp_alu("st", 8'h80, 4'b0011);

    // set ops, compare holding answer, NOP zeroing answer and holding flags
    step(OP_SLT,  8'hC0, 8'h01); exp_alu("slt",  8'h01, 4'b0000);
    step(OP_CMP,  8'hC0, 8'h01); exp_alu("cmp",  8'h01, 4'b0010);
    step(OP_NOP,  8'hC0, 8'h01); exp_alu("nop",  8'h00, 4'b0010);
    step(OP_SLTU, 8'hC0, 8'h01); exp_alu("sltu", 8'h00, 4'b0100);
    step(OP_SEQ,  8'h22, 8'h22); exp_alu("seq",  8'h01, 4'b0000);
    step(OP_SNE,  8'h22, 8'h22); exp_alu("sne",  8'h00, 4'b0100);

    // shifts and rotates
    step(OP_ASR, 8'h81, 8'h00);  exp_alu("asr", 8'hC0, 4'b1010);
    step(OP_SHR, 8'h81, 8'h00);  exp_alu("shr", 8'h40, 4'b1000);
    step(OP_ROL, 8'h81, 8'h00);  exp_alu("rol", 8'h03, 4'b0000);
    step(OP_ROR, 8'h81, 8'h00);  exp_alu("ror", 8'hC0, 4'b0010);

    // increment / decrement / negate overflow and carry edges
    step(OP_INC, 8'h7F, 8'h00);  exp_alu("inc7f", 8'h80, 4'b0011);
    step(OP_INC, 8'hFF, 8'h00);  exp_alu("incff", 8'h00, 4'b1100);
    step(OP_SBB, 8'h10, 8'h10);  exp_alu("sbb",   8'hFF, 4'b1010);
    step(OP_DEC, 8'h80, 8'h00);  exp_alu("dec80", 8'h7F, 4'b0001);
    step(OP_DEC, 8'h00, 8'h00);  exp_alu("dec00", 8'hFF, 4'b1010);
    step(OP_NEG, 8'h80, 8'h00);  exp_alu("neg80", 8'h80, 4'b1011);

    // logic / move group
    step(OP_NOT,  8'h0F, 8'h30); exp_alu("not",  8'hF0, 4'b0010);
    step(OP_NOR,  8'h0F, 8'h30); exp_alu("nor",  8'hC0, 4'b0010);
    step(OP_XNOR, 8'h0F, 8'h30); exp_alu("xnor", 8'hC0, 4'b0010);
    step(OP_SWAP, 8'h3C, 8'h00); exp_alu("swap", 8'hC3, 4'b0010);
    step(OP_PASS, 8'h3C, 8'h00); exp_alu("pass", 8'h3C, 4'b0000);
    step(OP_MOV,  8'h3C, 8'h00); exp_alu("mov",  8'h00, 4'b0100);
    bus.data_in = 8'h5A;
    step(OP_LDI,  8'h00, 8'h00); exp_alu("ldi",  8'h5A, 4'b0000);

    // reset during a multiply, then recompute after release
    reset      = 1'b0;
    bus.RW_dec = 5'd3;
    step(OP_MULH, 8'h40, 8'h08);
    exp_alu("rst_mid", 8'h00, 4'b0000);
    exp_ctl("rst_mid", 8'h00, 8'h00, 3'b000, 5'd0);
    reset = 1'b1;
    step(OP_MULH, 8'h40, 8'h08);
    exp_alu("mulh", 8'h02, 4'b1001);
    exp_ctl("mulh", 8'h5A, 8'h08, 3'b000, 5'd3);
    step(OP_MULL, 8'h40, 8'h08); exp_alu("mull", 8'h00, 4'b1101);
    step(OP_ADC,  8'h01, 8'h01); exp_alu("adc2", 8'h03, 4'b0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
